// File: rtl/mj_spare_pkg.sv
// Shared definitions for the ECO spare-logic bank: mode encodings and default sizing.
package mj_spare_pkg;

    localparam logic [1:0] SPARE_REG  = 2'b00;
    localparam logic [1:0] SPARE_SYNC = 2'b01;
    localparam logic [1:0] SPARE_CNT  = 2'b10;
    localparam logic [1:0] SPARE_XACC = 2'b11;

    localparam int SPARE_NUM_CH_DEF      = 4;
    localparam int SPARE_WIDTH_DEF       = 8;
    localparam int SPARE_SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/mj_spare_ch.sv
// One spare channel: state register, synchroniser chain, terminal-count flop and output mux.
module mj_spare_ch
    import mj_spare_pkg::*;
#(
    parameter int WIDTH       = SPARE_WIDTH_DEF,
    parameter int SYNC_STAGES = SPARE_SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    logic [WIDTH-1:0]                  st;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            st   <= '0;
            sync <= '0;
            tc   <= 1'b0;
        end else if (clr) begin
            st   <= '0;
            sync <= '0;
            tc   <= 1'b0;
        end else begin
            tc <= 1'b0;
            case (mode)
                SPARE_REG: begin
                    if (en) st <= d;
                end
                SPARE_SYNC: begin
                    // Free-running shift; enable deliberately has no effect here.
                    sync[0] <= d;
                    for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
                end
                SPARE_CNT: begin
                    if (en) begin
                        st <= st + WIDTH'(1);
                        tc <= &st;
                    end
                end
                default: begin
                    if (en) st <= st ^ d;
                end
            endcase
        end
    end

    assign q = (mode == SPARE_SYNC) ? sync[SYNC_STAGES-1] : st;

endmodule

// File: rtl/mj_spare_bank.sv
// Bank of NUM_CH independent ECO spare channels; this level only slices the flat buses.
module mj_spare_bank
    import mj_spare_pkg::*;
#(
    parameter int NUM_CH      = SPARE_NUM_CH_DEF,
    parameter int WIDTH       = SPARE_WIDTH_DEF,
    parameter int SYNC_STAGES = SPARE_SYNC_STAGES_DEF
) (
    input  logic                    clk,
    input  logic                    reset_l,
    input  logic [NUM_CH*WIDTH-1:0] spare_in,
    input  logic [NUM_CH-1:0]       spare_en,
    input  logic [NUM_CH-1:0]       spare_clr,
    input  logic [NUM_CH*2-1:0]     spare_mode,
    output logic [NUM_CH*WIDTH-1:0] spare_out,
    output logic [NUM_CH-1:0]       spare_tc
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        mj_spare_ch #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk     (clk),
            .reset_l (reset_l),
            .d       (spare_in[k*WIDTH +: WIDTH]),
            .en      (spare_en[k]),
            .clr     (spare_clr[k]),
            .mode    (spare_mode[k*2 +: 2]),
            .q       (spare_out[k*WIDTH +: WIDTH]),
            .tc      (spare_tc[k])
        );
    end

endmodule

// File: tb/tb_mj_spare_bank.sv
// Directed bench for mj_spare_bank: reset, REG/XACC, SYNC latency, CNT wrap, priority, async reset.
module tb_mj_spare_bank;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;

    logic                           clk = 1'b0;
    logic                           reset_l;
    logic [NUM_CH-1:0][WIDTH-1:0]   in_a;
    logic [NUM_CH-1:0]              en_a;
    logic [NUM_CH-1:0]              clr_a;
    logic [NUM_CH-1:0][1:0]         mode_a;
    logic [NUM_CH*WIDTH-1:0]        spare_out;
    logic [NUM_CH-1:0]              spare_tc;
    logic [NUM_CH-1:0][WIDTH-1:0]   out_a;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mj_spare_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .spare_in   (in_a),
        .spare_en   (en_a),
        .spare_clr  (clr_a),
        .spare_mode (mode_a),
        .spare_out  (spare_out),
        .spare_tc   (spare_tc)
    );

    assign out_a = spare_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and checks run 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] seq [4];
    logic [WIDTH-1:0] prev;

    initial begin
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        reset_l = 1'b0;
        in_a = '0; en_a = '0; clr_a = '0; mode_a = '0;

        // Reset / inert bank
        #3;
        chk("rst_out", spare_out, 0);
        chk("rst_tc", spare_tc, 0);
        step(); step();
        reset_l = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("inert_out", spare_out, 0);
            chk("inert_tc", spare_tc, 0);
        end
        #2 reset_l = 1'b0;
        #1 chk("inert_async_out", spare_out, 0);
        step();
        reset_l = 1'b1;
        step();
        chk("inert_post_out", spare_out, 0);

        // REG then XACC on ch0
        mode_a[0] = 2'b00; en_a[0] = 1'b1; in_a[0] = 8'hA5;
        step();
        chk("reg_load", out_a[0], 8'hA5);
        en_a[0] = 1'b0; in_a[0] = 8'h11;
        step();
        chk("reg_hold1", out_a[0], 8'hA5);
        step();
        chk("reg_hold2", out_a[0], 8'hA5);
        mode_a[0] = 2'b11; en_a[0] = 1'b1; in_a[0] = 8'hFF;
        step();
        chk("xacc", out_a[0], 8'h5A);
        en_a[0] = 1'b0;

        // SYNC on ch1: two-cycle latency, en ignored
        mode_a[1] = 2'b01; in_a[1] = 8'h00;
        step(); step();
        chk("sync_zero", out_a[1], 8'h00);
        in_a[1] = 8'h3C;
        step();
        chk("sync_lat1", out_a[1], 8'h00);
        step();
        chk("sync_lat2", out_a[1], 8'h3C);
        prev = 8'h3C;
        for (int j = 0; j < 4; j++) begin
            in_a[1] = seq[j];
            step();
            chk("sync_seq", out_a[1], prev);
            prev = seq[j];
        end
        step();
        chk("sync_seq_last", out_a[1], 8'h44);

        // CNT wrap on ch2, preloaded via REG
        mode_a[2] = 2'b00; en_a[2] = 1'b1; in_a[2] = 8'hFE;
        step();
        chk("cnt_preload", out_a[2], 8'hFE);
        mode_a[2] = 2'b10;
        step();
        chk("cnt_ff", out_a[2], 8'hFF);
        chk("cnt_ff_tc", spare_tc[2], 1'b0);
        step();
        chk("cnt_wrap", out_a[2], 8'h00);
        chk("cnt_wrap_tc", spare_tc[2], 1'b1);
        step();
        chk("cnt_one", out_a[2], 8'h01);
        chk("cnt_one_tc", spare_tc[2], 1'b0);
        en_a[2] = 1'b0;
        step();
        chk("cnt_hold", out_a[2], 8'h01);

        // clr beats en on a wrap edge of ch3; other channels untouched
        mode_a[3] = 2'b00; en_a[3] = 1'b1; in_a[3] = 8'hFF;
        step();
        chk("pri_preload", out_a[3], 8'hFF);
        mode_a[3] = 2'b10; clr_a[3] = 1'b1;
        step();
        chk("pri_out", out_a[3], 8'h00);
        chk("pri_tc", spare_tc, 0);
        chk("pri_ch0", out_a[0], 8'h5A);
        chk("pri_ch1", out_a[1], 8'h44);
        chk("pri_ch2", out_a[2], 8'h01);
        clr_a[3] = 1'b0;
        step();
        chk("pri_resume", out_a[3], 8'h01);
        en_a[3] = 1'b0;

        // Mode change switches the output mux in the same cycle
        mode_a[0] = 2'b01;
        #1 chk("mux_switch", out_a[0], 8'h00);
        mode_a[0] = 2'b11;
        #1 chk("mux_back", out_a[0], 8'h5A);

        // Async reset mid-count on ch2 at 0x80
        mode_a[2] = 2'b00; en_a[2] = 1'b1; in_a[2] = 8'h80;
        step();
        chk("ar_preload", out_a[2], 8'h80);
        mode_a[2] = 2'b10;
        #2 reset_l = 1'b0;
        #1 chk("ar_async_out", spare_out, 0);
        chk("ar_async_tc", spare_tc, 0);
        step();
        reset_l = 1'b1;
        step();
        chk("ar_restart", out_a[2], 8'h01);
        chk("ar_restart_tc", spare_tc[2], 1'b0);
        chk("ar_ch0", out_a[0], 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
